// File: rtl/parking_gate_arbiter.sv
// Barrier gate arbiter: shares one gate between the entry and exit lanes, tracks lot
// occupancy, refuses entry when the lot is full and closes an open gate that nobody uses.
module parking_gate_arbiter #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int OPEN_CYCLES = 16,
  parameter int TMR_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             gate_open,
  output logic             deny_entry,
  output logic             timeout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy
);

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSE} state_t;

  localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             last_exit_q, last_exit_d;
  logic             entry_grant_q, entry_grant_d;
  logic             exit_grant_q, exit_grant_d;
  logic             gate_open_q, gate_open_d;
  logic             deny_q, deny_d;
  logic             timeout_q, timeout_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ent_ok, ext_ok, pick_exit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CAP_C) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  always_comb begin
    ent_ok    = entry_req & ~full_q;
    ext_ok    = exit_req & ~empty_q;
    // On a tie the lane not served last wins; last_exit_q=0 after reset, so exit goes first.
    pick_exit = ext_ok & (~ent_ok | ~last_exit_q);

    state_d       = state_q;
    timer_d       = timer_q;
    occ_d         = occ_q;
    last_exit_d   = last_exit_q;
    gate_open_d   = gate_open_q;
    entry_grant_d = 1'b0;
    exit_grant_d  = 1'b0;
    deny_d        = 1'b0;
    timeout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        deny_d  = entry_req & full_q & ~ext_ok;
        if (pick_exit) begin
          state_d      = OPEN_OUT;
          exit_grant_d = 1'b1;
          last_exit_d  = 1'b1;
          gate_open_d  = 1'b1;
        end else if (ent_ok) begin
          state_d       = OPEN_IN;
          entry_grant_d = 1'b1;
          last_exit_d   = 1'b0;
          gate_open_d   = 1'b1;
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if (car_passed) begin
          occ_d       = (state_q == OPEN_IN) ? sat_inc(occ_q) : sat_dec(occ_q);
          state_d     = CLOSE;
          gate_open_d = 1'b0;
        end else if (timer_q == TMR_LAST) begin
          timeout_d   = 1'b1;
          state_d     = CLOSE;
          gate_open_d = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d     = '0;
        gate_open_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    full_d  = (occ_d == CAP_C);
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      occ_q         <= '0;
      last_exit_q   <= 1'b0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      gate_open_q   <= 1'b0;
      deny_q        <= 1'b0;
      timeout_q     <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      occ_q         <= occ_d;
      last_exit_q   <= last_exit_d;
      entry_grant_q <= entry_grant_d;
      exit_grant_q  <= exit_grant_d;
      gate_open_q   <= gate_open_d;
      deny_q        <= deny_d;
      timeout_q     <= timeout_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
    end
  end

  assign entry_grant = entry_grant_q;
  assign exit_grant  = exit_grant_q;
  assign gate_open   = gate_open_q;
  assign deny_entry  = deny_q;
  assign timeout     = timeout_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a lane/occupancy reference model.
module tb_parking_gate_arbiter;
  localparam int CAP = 8, CNT_W = 4, OPEN_CYCLES = 16, TMR_W = 5;

  logic clk = 1'b0;
  logic reset, entry_req, exit_req, car_passed;
  logic entry_grant, exit_grant, gate_open, deny_entry, timeout, full, empty;
  logic [CNT_W-1:0] occupancy;

  int n_pass = 0, n_total = 0;

  // Reference model: m_dir = +1 gate open for an entering car, -1 for a leaving car, 0 shut.
  int m_occ, m_dir, m_age;
  bit m_close, m_last_exit;
  bit x_eg, x_xg, x_deny, x_to;

  always #5 clk = ~clk;

  parking_gate_arbiter #(
    .CAPACITY(CAP), .CNT_W(CNT_W), .OPEN_CYCLES(OPEN_CYCLES), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .car_passed(car_passed), .entry_grant(entry_grant), .exit_grant(exit_grant),
    .gate_open(gate_open), .deny_entry(deny_entry), .timeout(timeout),
    .full(full), .empty(empty), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_occ = 0; m_dir = 0; m_age = 0; m_close = 0; m_last_exit = 0;
    x_eg = 0; x_xg = 0; x_deny = 0; x_to = 0;
  endtask

  task automatic model_edge(input bit e, input bit x, input bit cp);
    bit can_in, can_out, go_out;
    x_eg = 0; x_xg = 0; x_deny = 0; x_to = 0;
    if (m_close) begin
      m_close = 0;
    end else if (m_dir != 0) begin
      if (cp) begin
        m_occ = m_occ + m_dir;
        if (m_occ > CAP) m_occ = CAP;
        if (m_occ < 0) m_occ = 0;
        m_dir = 0; m_close = 1;
      end else if (m_age == OPEN_CYCLES - 1) begin
        x_to = 1; m_dir = 0; m_close = 1;
      end else begin
        m_age++;
      end
    end else begin
      can_in  = e && (m_occ < CAP);
      can_out = x && (m_occ > 0);
      go_out  = can_out && (!can_in || !m_last_exit);
      x_deny  = e && (m_occ == CAP) && !can_out;
      if (go_out) begin
        m_dir = -1; m_age = 0; x_xg = 1; m_last_exit = 1;
      end else if (can_in) begin
        m_dir = 1; m_age = 0; x_eg = 1; m_last_exit = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".entry_grant"}, 32'(entry_grant), 32'(x_eg));
    chk({tag, ".exit_grant"},  32'(exit_grant),  32'(x_xg));
    chk({tag, ".gate_open"},   32'(gate_open),   32'(m_dir != 0));
    chk({tag, ".deny_entry"},  32'(deny_entry),  32'(x_deny));
    chk({tag, ".timeout"},     32'(timeout),     32'(x_to));
    chk({tag, ".occupancy"},   32'(occupancy),   m_occ);
    chk({tag, ".full"},        32'(full),        32'(m_occ == CAP));
    chk({tag, ".empty"},       32'(empty),       32'(m_occ == 0));
  endtask

  task automatic cycle(input string tag, input bit e, input bit x, input bit cp);
    @(negedge clk);
    entry_req = e; exit_req = x; car_passed = cp;
    @(posedge clk);
    model_edge(e, x, cp);
    #1;
    check_all(tag);
  endtask

  // One complete gate cycle: request, car passes on the first open cycle, gate closes.
  task automatic serve(input string tag, input bit ent);
    cycle(tag, ent, !ent, 1'b0);
    cycle(tag, 1'b0, 1'b0, 1'b1);
    cycle(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; car_passed = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    cycle("idle", 1'b0, 1'b0, 1'b0);
    cycle("exit_empty", 1'b0, 1'b1, 1'b0);

    // Single entry with the car passing three cycles into the open window
    cycle("t2_req", 1'b1, 1'b0, 1'b0);
    chk("t2_grant", 32'(entry_grant), 1);
    cycle("t2_open", 1'b0, 1'b0, 1'b0);
    cycle("t2_open", 1'b0, 1'b0, 1'b0);
    cycle("t2_pass", 1'b0, 1'b0, 1'b1);
    chk("t2_occ", 32'(occupancy), 1);
    chk("t2_closed", 32'(gate_open), 0);
    cycle("t2_close", 1'b0, 1'b0, 1'b0);

    // Fill the lot, then check refusal and recovery through an exit
    for (int i = 0; i < CAP - 1; i++) serve("t3_fill", 1'b1);
    chk("t3_full", 32'(full), 1);
    cycle("t3_deny", 1'b1, 1'b0, 1'b0);
    chk("t3_deny_level", 32'(deny_entry), 1);
    cycle("t3_deny", 1'b1, 1'b0, 1'b0);
    cycle("t3_exit", 1'b1, 1'b1, 1'b0);
    chk("t3_exit_grant", 32'(exit_grant), 1);
    chk("t3_deny_clr", 32'(deny_entry), 0);
    cycle("t3_exit_pass", 1'b1, 1'b0, 1'b1);
    chk("t3_occ7", 32'(occupancy), CAP - 1);
    cycle("t3_close", 1'b1, 1'b0, 1'b0);
    cycle("t3_reentry", 1'b1, 1'b0, 1'b0);
    chk("t3_reentry_grant", 32'(entry_grant), 1);
    cycle("t3_pass", 1'b0, 1'b0, 1'b1);
    cycle("t3_close", 1'b0, 1'b0, 1'b0);

    // Reach occupancy 4 with entry served last, then hold both requests
    for (int i = 0; i < 5; i++) serve("t4_drain", 1'b0);
    serve("t4_in", 1'b1);
    chk("t4_occ4", 32'(occupancy), 4);
    for (int k = 0; k < 4; k++) begin
      cycle("t4_tie", 1'b1, 1'b1, 1'b0);
      chk("t4_tie_exit", 32'(exit_grant), 32'((k % 2) == 0));
      chk("t4_tie_entry", 32'(entry_grant), 32'((k % 2) == 1));
      cycle("t4_pass", 1'b1, 1'b1, 1'b1);
      cycle("t4_close", 1'b1, 1'b1, 1'b0);
    end

    // Unused gate times out after OPEN_CYCLES open cycles
    cycle("t5_req", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < OPEN_CYCLES - 1; i++) cycle("t5_wait", 1'b0, 1'b0, 1'b0);
    chk("t5_still_open", 32'(gate_open), 1);
    cycle("t5_timeout", 1'b0, 1'b0, 1'b0);
    chk("t5_to_pulse", 32'(timeout), 1);
    chk("t5_occ", 32'(occupancy), 4);
    cycle("t5_close", 1'b0, 1'b0, 1'b0);
    // Car on the last open cycle is counted instead of timing out
    cycle("t5b_req", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < OPEN_CYCLES - 1; i++) cycle("t5b_wait", 1'b0, 1'b0, 1'b0);
    cycle("t5b_last", 1'b0, 1'b0, 1'b1);
    chk("t5b_no_to", 32'(timeout), 0);
    chk("t5b_occ", 32'(occupancy), 5);
    cycle("t5b_close", 1'b0, 1'b0, 1'b0);

    // Reset while the gate is open for a leaving car
    serve("t6_out", 1'b0);
    serve("t6_out", 1'b0);
    cycle("t6_req", 1'b0, 1'b1, 1'b0);
    cycle("t6_open", 1'b0, 1'b0, 1'b0);
    chk("t6_open_before", 32'(gate_open), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("t6_gate_async", 32'(gate_open), 0);
    chk("t6_occ_clr", 32'(occupancy), 0);
    chk("t6_empty", 32'(empty), 1);
    @(negedge clk);
    reset = 1'b0;
    cycle("t6_exit_ign", 1'b0, 1'b1, 1'b0);
    cycle("t6_exit_ign", 1'b0, 1'b1, 1'b0);
    chk("t6_no_grant", 32'(exit_grant), 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
